// File: rtl/seq_detect_pkg.sv
// Shared types and reset constants for the serial pattern-detector run controller.
package seq_detect_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned LEN_W       = 4;

  localparam logic [7:0]       PATTERN_RST = 8'b0001_1011;
  localparam logic [LEN_W-1:0] LEN_RST     = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// Serial history, fill tracking and masked pattern compare; hit is combinational on the current sample.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               din_valid,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               full;

  assign window = {hist, din};

  // Only the low len bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign full = (fill >= (len - LEN_W'(1)));
  assign hit  = en && din_valid && full && (((window ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en && din_valid) begin
      if (hit && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= window[MAX_LEN-2:0];
        if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: configuration registers, run/idle/done state machine and saturating match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               din_valid,
  input  logic               din,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_clamped;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic               run;
  logic               launch;
  logic               hit;
  logic               target_hit;

  assign run        = (state == ST_RUN);
  assign launch     = start && !abort && !run;
  assign target_hit = hit && (target_q != '0) &&
                      (({1'b0, match_count} + (CNT_W+1)'(1)) == {1'b0, target_q});
  assign match      = hit;

  // Stored length is always in 1..MAX_LEN so the core never sees a degenerate mask.
  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamped = LEN_W'(MAX_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Abort outranks both start and a target hit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !abort) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (target_hit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (abort)      state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= MAX_LEN'(PATTERN_RST);
      len_q     <= LEN_RST;
      overlap_q <= 1'b0;
      target_q  <= '0;
    end else if (cfg_we && !run) begin
      pattern_q <= cfg_pattern;
      len_q     <= len_clamped;
      overlap_q <= cfg_overlap;
      target_q  <= cfg_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      match_count <= '0;
    end else if (hit && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (run),
    .clr       (launch),
    .din_valid (din_valid),
    .din       (din),
    .pattern   (pattern_q),
    .len       (len_q),
    .overlap   (overlap_q),
    .hit       (hit)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed match, count and status expectations.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic       din_valid;
  logic       din;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .MAX_LEN (8),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .din_valid   (din_valid),
    .din         (din),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one valid sample, check match mid-cycle, then clock it in.
  task automatic send_bit(input logic b, input logic exp_m, input string tag);
    din_valid = 1'b1;
    din       = b;
    #1;
    check(tag, 32'(match), 32'(exp_m));
    tick();
    din_valid = 1'b0;
  endtask

  // Bits and expected match flags are given MSB-first (bit n-1 is the first sample).
  task automatic send_stream(input logic [15:0] bits, input int n, input logic [15:0] exp,
                             input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], exp[i], $sformatf("%s_s%0d", tag, n - i));
    end
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                           input logic [7:0] tgt, input logic with_start);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_target  = tgt;
    start       = with_start;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    cfg_target = '0; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(match_count), 0);
    send_bit(1'b1, 1'b0, "idle_no_match");

    // Default pattern 11011, non-overlapping.
    din_valid = 1'b1; din = 1'b1;
    pulse_start();
    din_valid = 1'b0;
    check("start_busy", 32'(busy), 1);
    send_stream(16'b1101_1011, 8, 16'b0000_1000, "nonovl");
    check("nonovl_count", 32'(match_count), 1);
    pulse_abort();
    check("abort_busy", 32'(busy), 0);
    check("abort_keep_count", 32'(match_count), 1);

    // Overlapping.
    configure(8'b0001_1011, 4'd5, 1'b1, 8'd0, 1'b0);
    pulse_start();
    send_stream(16'b1101_1011, 8, 16'b0000_1001, "ovl");
    check("ovl_count", 32'(match_count), 2);
    pulse_abort();

    // Target stop after two matches.
    configure(8'b0001_1011, 4'd5, 1'b0, 8'd2, 1'b1);
    send_stream(16'b11011_11011, 10, 16'b00001_00001, "tgt");
    check("tgt_done", 32'(done), 1);
    check("tgt_busy", 32'(busy), 0);
    send_stream(16'b11011, 5, 16'b00000, "tgt_after");
    check("tgt_count", 32'(match_count), 2);
    pulse_abort();
    check("done_abort", 32'(done), 0);

    // Gaps between valid samples; invalid din is the inverted bit.
    configure(8'b0001_1011, 4'd5, 1'b0, 8'd0, 1'b1);
    for (int i = 4; i >= 0; i--) begin
      logic [4:0] pat5;
      pat5 = 5'b11011;
      send_bit(pat5[i], (i == 0), $sformatf("gap_s%0d", 5 - i));
      din = ~pat5[i];
      tick();
    end
    check("gap_count", 32'(match_count), 1);
    configure(8'b0000_0000, 4'd2, 1'b1, 8'd1, 1'b0);
    send_stream(16'b11011, 5, 16'b00001, "cfg_in_run");
    check("cfg_in_run_count", 32'(match_count), 2);
    check("cfg_in_run_busy", 32'(busy), 1);
    pulse_abort();

    // Short pattern 101, overlapping, configured together with start.
    configure(8'b0000_0101, 4'd3, 1'b1, 8'd0, 1'b1);
    send_stream(16'b10101, 5, 16'b00101, "p101");
    check("p101_count", 32'(match_count), 2);
    pulse_abort();

    // Length above MAX_LEN clamps to 8.
    configure(8'b1101_1011, 4'd15, 1'b0, 8'd0, 1'b1);
    send_stream(16'b1101_1011, 8, 16'b0000_0001, "len_clamp");
    pulse_abort();

    // start and abort together in IDLE.
    start = 1'b1;
    pulse_abort();
    start = 1'b0;
    check("start_abort_busy", 32'(busy), 0);

    // Abort in the cycle of a target-hitting match.
    configure(8'b0001_1011, 4'd5, 1'b0, 8'd1, 1'b1);
    send_stream(16'b1101, 4, 16'b0000, "abort_hit");
    abort = 1'b1;
    send_bit(1'b1, 1'b1, "abort_hit_s5");
    abort = 1'b0;
    check("abort_hit_busy", 32'(busy), 0);
    check("abort_hit_done", 32'(done), 0);
    check("abort_hit_count", 32'(match_count), 1);

    // Length 0 clamps to 1; 300 ones saturate the counter.
    configure(8'b0000_0001, 4'd0, 1'b0, 8'd0, 1'b1);
    din_valid = 1'b1;
    din       = 1'b1;
    repeat (300) tick();
    din_valid = 1'b0;
    check("sat_count", 32'(match_count), 255);
    check("sat_busy", 32'(busy), 1);

    // Reset mid-run restores everything, including configuration.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run_busy", 32'(busy), 0);
    check("rst_run_count", 32'(match_count), 0);
    pulse_start();
    send_stream(16'b11011, 5, 16'b00001, "rst_cfg");
    check("rst_cfg_count", 32'(match_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
